// File: rtl/regfile_dump_unit.sv
// Register file dump engine: halts the core, sweeps regfile read port A and
// streams every register value with its index over a valid/ready link.
module regfile_dump_unit #(
    parameter int NUM_REGS      = 32,
    parameter int SETTLE_CYCLES = 1,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  halt_req,
    input  logic                  halt_ack,
    output logic                  dump_sel,
    output logic [4:0]            dump_readReg,
    input  logic [DATA_WIDTH-1:0] data_readRegA,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [4:0]            out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HALT   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_SEND   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [4:0] LAST_IDX    = 5'(NUM_REGS - 1);
    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

    logic [2:0]            state_r,     state_s;
    logic [4:0]            index_r,     index_s;
    logic [2:0]            cnt_r,       cnt_s;
    logic                  halt_req_r,  halt_req_s;
    logic                  dump_sel_r,  dump_sel_s;
    logic [4:0]            dump_reg_r,  dump_reg_s;
    logic                  out_valid_r, out_valid_s;
    logic [DATA_WIDTH-1:0] out_data_r,  out_data_s;
    logic [4:0]            out_index_r, out_index_s;
    logic                  out_last_r,  out_last_s;
    logic                  busy_r,      busy_s;
    logic                  done_r,      done_s;
    logic [DATA_WIDTH-1:0] checksum_r,  checksum_s;

    // Next-state and next-output computation for the dump sequencer.
    always_comb begin
        state_s     = state_r;
        index_s     = index_r;
        cnt_s       = cnt_r;
        halt_req_s  = halt_req_r;
        dump_sel_s  = dump_sel_r;
        dump_reg_s  = dump_reg_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        out_index_s = out_index_r;
        out_last_s  = out_last_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        checksum_s  = checksum_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s    = ST_HALT;
                    halt_req_s = 1'b1;
                    busy_s     = 1'b1;
                    checksum_s = {DATA_WIDTH{1'b0}};
                    index_s    = 5'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_HALT: begin
                if (halt_ack) begin
                    state_s    = ST_SETTLE;
                    dump_sel_s = 1'b1;
                    dump_reg_s = index_r;
                    cnt_s      = 3'd0;
                end else begin
                    state_s = ST_HALT;
                end
            end

            // The regfile read path is combinational; wait for it to settle
            // on the new address before sampling.
            ST_SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_s     = ST_SEND;
                    out_data_s  = data_readRegA;
                    out_index_s = index_r;
                    out_valid_s = 1'b1;
                    out_last_s  = (index_r == LAST_IDX);
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end

            ST_SEND: begin
                if (out_ready) begin
                    checksum_s  = checksum_r + out_data_r;
                    out_valid_s = 1'b0;
                    out_last_s  = 1'b0;
                    if (out_last_r) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_s    = ST_SETTLE;
                        index_s    = index_r + 5'd1;
                        dump_reg_s = index_r + 5'd1;
                        cnt_s      = 3'd0;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end

            ST_DONE: begin
                state_s    = ST_IDLE;
                halt_req_s = 1'b0;
                dump_sel_s = 1'b0;
                busy_s     = 1'b0;
            end

            default: begin
                state_s     = ST_IDLE;
                halt_req_s  = 1'b0;
                dump_sel_s  = 1'b0;
                out_valid_s = 1'b0;
                out_last_s  = 1'b0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any dump in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            index_r     <= 5'd0;
            cnt_r       <= 3'd0;
            halt_req_r  <= 1'b0;
            dump_sel_r  <= 1'b0;
            dump_reg_r  <= 5'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_index_r <= 5'd0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            checksum_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r     <= state_s;
            index_r     <= index_s;
            cnt_r       <= cnt_s;
            halt_req_r  <= halt_req_s;
            dump_sel_r  <= dump_sel_s;
            dump_reg_r  <= dump_reg_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_index_r <= out_index_s;
            out_last_r  <= out_last_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            checksum_r  <= checksum_s;
        end
    end

    assign halt_req     = halt_req_r;
    assign dump_sel     = dump_sel_r;
    assign dump_readReg = dump_reg_r;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_index    = out_index_r;
    assign out_last     = out_last_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign checksum     = checksum_r;

endmodule
